fcs_insert: RTL and testbench
=============================

FCS_INSERT -- requirements
Module: fcs_insert

Interface
REQ-001 P_MIN_LEN, default 60, minimum frame length in bytes before FCS; shorter frames are zero-padded up to this length.
REQ-002 P_PAD_EN, default 1, 1 = padding enabled, 0 = no padding.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stream_in_startofpacket  input  1  first byte of frame.
REQ-006 stream_in_endofpacket  input  1  last payload byte of frame.
REQ-007 stream_in_valid  input  1  input beat valid.
REQ-008 stream_in_data  input  8  payload byte.
REQ-009 stream_in_error  input  1  upstream error on this beat.
REQ-010 stream_in_ready  output  1  block accepts the input beat.
REQ-011 stream_out_startofpacket  output  1  first byte of output frame.
REQ-012 stream_out_endofpacket  output  1  last FCS byte.
REQ-013 stream_out_valid  output  1  output beat valid.
REQ-014 stream_out_data  output  8  payload, pad or FCS byte.
REQ-015 stream_out_error  output  1  frame error flag, asserted only with endofpacket.
REQ-016 stream_out_ready  input  1  downstream accepts the output beat.

Function
REQ-017 A transfer occurs on a beat where valid=1 and ready=1 (both sides); a pending output beat holds all output fields stable until it is transferred.
REQ-018 The output is a single register stage: an accepted input byte appears on the output on the next cycle (latency 1).
REQ-019 stream_in_ready = (state is S_IDLE or S_DATA) and (stream_out_valid=0 or stream_out_ready=1).
REQ-020 States: S_IDLE, S_DATA, S_PAD, S_FCS.
REQ-021 Transitions:
- S_IDLE -> S_DATA on an accepted sop beat without eop.
- S_IDLE or S_DATA -> S_PAD on an accepted eop beat when P_PAD_EN=1 and byte count < P_MIN_LEN.
- Otherwise on an accepted eop beat -> S_FCS.
- S_PAD -> S_FCS after emitting the last pad byte.
- S_FCS -> S_IDLE after the 4th FCS byte transfers.
REQ-022 In S_IDLE, input beats without sop are accepted and discarded; no output is produced.
REQ-023 A sop=1 beat seen in S_DATA is forwarded as data with startofpacket cleared and no restart.
REQ-024 A single-beat frame (sop=1 and eop=1) is legal.
REQ-025 Byte counter: 16-bit, counts payload plus pad bytes, saturates at 16'hFFFF.
REQ-026 Pad bytes are 8'h00, are included in the CRC, and are emitted back-to-back while stream_out_ready allows.
REQ-027 CRC: reflected CRC-32, polynomial 32'h04C11DB7, register initialised to 32'hFFFFFFFF on every sop beat, updated once per output payload/pad byte with data LSB first.
REQ-028 FCS = ~crc; bytes are sent in order FCS[7:0], FCS[15:8], FCS[23:16], FCS[31:24].
REQ-029 An error flag is latched if stream_in_error=1 on any accepted beat of the frame. When latched:
- all four FCS bytes are sent bit-inverted;
- stream_out_error=1 on the last FCS byte.
REQ-030 stream_out_startofpacket=1 on the first output byte only; stream_out_endofpacket=1 on the 4th FCS byte only.

Reset
REQ-031 While rst_n=0:
- state = S_IDLE; counter = 0; error latch = 0; CRC = 32'hFFFFFFFF;
- stream_out_valid, stream_out_startofpacket, stream_out_endofpacket and stream_out_error = 0; stream_out_data = 8'h00;
- stream_in_ready = 0.
REQ-032 A reset asserted mid-frame discards the partial frame; after release the block emits nothing until the next sop.

Structure
REQ-033 The shared package mac_pkg holds:
- stream_t;
- constants CRC32_POLY, CRC32_INIT (32'hFFFFFFFF), CRC32_RESIDUE (32'hC704DD7B), MIN_FRAME_LEN (60);
- function crc32_byte(crc, data), shared with the receive-side CRC checker.
REQ-034 fcs_insert has no sub-modules; the CRC update uses the package function.

Verification
REQ-035 "123456789" (sop on 8'h31, eop on 8'h39), P_PAD_EN=0, ready always 1 -> output is 9 bytes then 26 39 F4 CB, eop on CB, error=0.
REQ-036 14-byte frame, P_PAD_EN=1 -> 46 pad bytes of 00, then 4 FCS bytes (64 bytes total); passing this output through the receive CRC checker reports no error.
REQ-037 stream_out_ready toggled by a random 50% pattern -> output byte sequence identical to the ready=1 run, and no beat changes while valid=1 and ready=0.
REQ-038 stream_in_error=1 on byte 3 of a 64-byte frame -> FCS bytes equal the bitwise NOT of the correct FCS, and stream_out_error=1 with eop.
REQ-039 rst_n=0 for 1 cycle in the middle of S_FCS, then a new frame -> no stale FCS bytes are emitted, and the new frame's FCS is correct.
REQ-040 Single-beat frame 8'hAA, then a back-to-back second frame -> stream_in_ready=0 during the 59 pad beats and 4 FCS beats, then the second frame's sop is accepted.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: stream beat type, FSM states, CRC-32 constants and the
// byte-wise reflected CRC-32 update used by both the FCS inserter and the receive checker.
package mac_pkg;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] dat;
  } stream_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_FCS
  } fcs_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Bit-reversed CRC32_POLY, used by the LSB-first shift register.
  localparam logic [31:0] CRC32_POLY_RF = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam int          MIN_FRAME_LEN = 60;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_RF;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/fcs_insert.sv
// Appends pad bytes and a 4-byte CRC-32 FCS to each frame; one output register stage (latency 1).
// Input is stalled while padding or sending FCS, and whenever the held output beat is not taken.
module fcs_insert
  import mac_pkg::*;
#(
  parameter int unsigned P_MIN_LEN = MIN_FRAME_LEN,
  parameter bit          P_PAD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stream_in_startofpacket,
  input  logic       stream_in_endofpacket,
  input  logic       stream_in_valid,
  input  logic [7:0] stream_in_data,
  input  logic       stream_in_error,
  output logic       stream_in_ready,
  output logic       stream_out_startofpacket,
  output logic       stream_out_endofpacket,
  output logic       stream_out_valid,
  output logic [7:0] stream_out_data,
  output logic       stream_out_error,
  input  logic       stream_out_ready
);

  localparam logic [15:0] MIN_LEN = 16'(P_MIN_LEN);

  fcs_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic [1:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  stream_t     out_q, out_d;

  logic        out_free;
  logic        in_acc;
  logic [15:0] cnt_inc;
  logic [31:0] fcs;

  assign out_free        = !vld_q || stream_out_ready;
  assign stream_in_ready = rst_n && out_free && (state_q == S_IDLE || state_q == S_DATA);
  assign in_acc          = stream_in_valid && stream_in_ready;
  assign cnt_inc         = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // An errored frame gets its whole FCS inverted so downstream checkers reject it.
  assign fcs             = ~crc_q ^ {32{err_q}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    err_d   = err_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    out_d   = out_q;
    if (out_free) begin
      vld_d     = 1'b0;
      out_d.sop = 1'b0;
      out_d.eop = 1'b0;
      out_d.err = 1'b0;
    end
    unique case (state_q)
      S_IDLE, S_DATA: begin
        if (in_acc && (state_q == S_DATA || stream_in_startofpacket)) begin
          vld_d     = 1'b1;
          out_d.dat = stream_in_data;
          out_d.sop = (state_q == S_IDLE);
          idx_d     = 2'd0;
          if (state_q == S_IDLE) begin
            crc_d = crc32_byte(CRC32_INIT, stream_in_data);
            cnt_d = 16'd1;
            err_d = stream_in_error;
          end else begin
            crc_d = crc32_byte(crc_q, stream_in_data);
            cnt_d = cnt_inc;
            err_d = err_q | stream_in_error;
          end
          if (stream_in_endofpacket) state_d = (P_PAD_EN && cnt_d < MIN_LEN) ? S_PAD : S_FCS;
          else                       state_d = S_DATA;
        end
      end
      S_PAD: begin
        if (out_free) begin
          vld_d     = 1'b1;
          out_d.dat = 8'h00;
          crc_d     = crc32_byte(crc_q, 8'h00);
          cnt_d     = cnt_inc;
          if (cnt_inc >= MIN_LEN) state_d = S_FCS;
        end
      end
      S_FCS: begin
        if (out_free) begin
          vld_d     = 1'b1;
          out_d.dat = 8'(fcs >> {idx_q, 3'b000});
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            out_d.eop = 1'b1;
            out_d.err = err_q;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      crc_q   <= CRC32_INIT;
      err_q   <= 1'b0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  assign stream_out_valid         = vld_q;
  assign stream_out_startofpacket = out_q.sop;
  assign stream_out_endofpacket   = out_q.eop;
  assign stream_out_error         = out_q.err;
  assign stream_out_data          = out_q.dat;

endmodule

// File: tb/tb_fcs_insert.sv
// Directed bench for fcs_insert: one padding instance (index 1) and one non-padding instance (index 0).
module tb_fcs_insert;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct {
    int   inst;
    int   len;
    int   err_idx;
    int   xsop;
    int   rmode;
    int   exp_total;
    logic exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_sop [2];
  logic       in_eop [2];
  logic       in_vld [2];
  logic       in_err [2];
  logic       in_rdy [2];
  logic [7:0] in_dat [2];
  logic       out_sop[2];
  logic       out_eop[2];
  logic       out_vld[2];
  logic       out_err[2];
  logic       out_rdy[2];
  logic [7:0] out_dat[2];

  int n_cmp = 0;
  int n_bad = 0;
  int hold_bad;
  int nfr;
  logic [7:0] pay[$];
  beat_t tx_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];

  always #5 clk = ~clk;

  fcs_insert #(.P_MIN_LEN(60), .P_PAD_EN(1'b0)) u_nopad (
    .clk(clk), .rst_n(rst_n),
    .stream_in_startofpacket(in_sop[0]), .stream_in_endofpacket(in_eop[0]),
    .stream_in_valid(in_vld[0]), .stream_in_data(in_dat[0]), .stream_in_error(in_err[0]),
    .stream_in_ready(in_rdy[0]),
    .stream_out_startofpacket(out_sop[0]), .stream_out_endofpacket(out_eop[0]),
    .stream_out_valid(out_vld[0]), .stream_out_data(out_dat[0]), .stream_out_error(out_err[0]),
    .stream_out_ready(out_rdy[0])
  );

  fcs_insert u_pad (
    .clk(clk), .rst_n(rst_n),
    .stream_in_startofpacket(in_sop[1]), .stream_in_endofpacket(in_eop[1]),
    .stream_in_valid(in_vld[1]), .stream_in_data(in_dat[1]), .stream_in_error(in_err[1]),
    .stream_in_ready(in_rdy[1]),
    .stream_out_startofpacket(out_sop[1]), .stream_out_endofpacket(out_eop[1]),
    .stream_out_valid(out_vld[1]), .stream_out_data(out_dat[1]), .stream_out_error(out_err[1]),
    .stream_out_ready(out_rdy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic fill_pay(input int len, input int seed);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'(i * 37 + seed * 11 + 5));
  endtask

  // Appends the frame held in pay[] to the stimulus and its expected output to exp_q.
  task automatic add_frame(input bit pad_en, input int err_idx, input int xsop);
    logic [31:0] crc, fcs;
    logic        e;
    int          n;
    crc = 32'hFFFFFFFF;
    e   = 1'b0;
    for (int i = 0; i < pay.size(); i++) begin
      tx_q.push_back('{pay[i], (i == 0 || i == xsop), (i == pay.size() - 1), (i == err_idx)});
      exp_q.push_back('{pay[i], (i == 0), 1'b0, 1'b0});
      crc = m_crc(crc, pay[i]);
      if (i == err_idx) e = 1'b1;
    end
    n = pay.size();
    while (pad_en && n < 60) begin
      exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
      crc = m_crc(crc, 8'h00);
      n++;
    end
    fcs = e ? crc : ~crc;
    for (int k = 0; k < 4; k++) exp_q.push_back('{fcs[8*k +: 8], 1'b0, (k == 3), (k == 3) && e});
    nfr++;
  endtask

  task automatic new_stream();
    tx_q.delete();
    exp_q.delete();
    nfr = 0;
  endtask

  task automatic run_stream(input int inst, input int rmode, input int stop_at, output int stalls);
    int    sent, cyc, eops;
    logic  pend;
    beat_t prev, cur;
    sent = 0; cyc = 0; eops = 0; pend = 1'b0; stalls = 0; hold_bad = 0;
    prev = '0;
    got_q.delete();
    while (eops < nfr && !(stop_at > 0 && got_q.size() >= stop_at) && cyc < 3000) begin
      @(negedge clk);
      out_rdy[inst] = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sent < tx_q.size()) begin
        in_vld[inst] = 1'b1;
        in_dat[inst] = tx_q[sent].dat;
        in_sop[inst] = tx_q[sent].sop;
        in_eop[inst] = tx_q[sent].eop;
        in_err[inst] = tx_q[sent].err;
      end else begin
        in_vld[inst] = 1'b0;
      end
      #1;
      cur = '{out_dat[inst], out_sop[inst], out_eop[inst], out_err[inst]};
      if (pend && (!out_vld[inst] || cur != prev)) hold_bad++;
      if (in_vld[inst] && in_rdy[inst]) sent++;
      else if (in_vld[inst]) stalls++;
      pend = 1'b0;
      if (out_vld[inst]) begin
        if (out_rdy[inst]) begin
          got_q.push_back(cur);
          if (cur.eop) eops++;
        end else begin
          pend = 1'b1;
          prev = cur;
        end
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout inst %0d: got %0d eops required %0d", inst, eops, nfr);
    end
    in_vld[inst]  = 1'b0;
    out_rdy[inst] = 1'b1;
  endtask

  task automatic check_stream(input string name);
    int nb;
    nb = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) nb++;
    chk({name, " len"}, got_q.size(), exp_q.size());
    chk({name, " beats"}, nb, 0);
    chk({name, " hold"}, hold_bad, 0);
  endtask

  function automatic logic [31:0] got_residue(input int from);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < got_q.size(); i++) c = m_crc(c, got_q[i].dat);
    return c;
  endfunction

  initial begin
    vec_t vt[10];
    int   st, seen;
    vt[0] = '{1, 14, -1, -1, 0, 64, 1'b0};
    vt[1] = '{1, 14, -1, -1, 1, 64, 1'b0};
    vt[2] = '{1, 64,  3, -1, 0, 68, 1'b1};
    vt[3] = '{1, 64,  3, -1, 1, 68, 1'b1};
    vt[4] = '{1, 60, -1, -1, 0, 64, 1'b0};
    vt[5] = '{1, 59, -1, -1, 1, 64, 1'b0};
    vt[6] = '{1, 20, -1,  5, 0, 64, 1'b0};
    vt[7] = '{0,  5, -1, -1, 1,  9, 1'b0};
    vt[8] = '{0,  1,  0, -1, 0,  5, 1'b1};
    vt[9] = '{1,  1,  0, -1, 1, 64, 1'b1};

    for (int k = 0; k < 2; k++) begin
      in_sop[k] = 1'b0; in_eop[k] = 1'b0; in_vld[k] = 1'b0;
      in_err[k] = 1'b0; in_dat[k] = 8'h00; out_rdy[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst vld", out_vld[1], 1'b0);
    chk("rst sop/eop/err", {out_sop[1], out_eop[1], out_err[1]}, 3'b000);
    chk("rst data", out_dat[1], 8'h00);
    chk("rst in_rdy", {in_rdy[1], in_rdy[0]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Beats without sop in idle are swallowed.
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_vld[1] = (i < 3); in_sop[1] = 1'b0; in_eop[1] = (i == 2); in_dat[1] = 8'h5A;
      #1;
      if (i == 0) chk("idle in_rdy", in_rdy[1], 1'b1);
      if (out_vld[1]) seen++;
    end
    in_vld[1] = 1'b0;
    chk("idle discard", seen, 0);

    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    new_stream();
    add_frame(1'b0, -1, -1);
    run_stream(0, 0, 0, st);
    check_stream("crc123456789");
    if (got_q.size() == 13) begin
      chk("fcs b0", got_q[9].dat, 8'h26);
      chk("fcs b1", got_q[10].dat, 8'h39);
      chk("fcs b2", got_q[11].dat, 8'hF4);
      chk("fcs b3", {got_q[12].dat, got_q[12].eop, got_q[12].err}, {8'hCB, 1'b1, 1'b0});
    end

    for (int v = 0; v < 10; v++) begin
      fill_pay(vt[v].len, v);
      new_stream();
      add_frame(vt[v].inst == 1, vt[v].err_idx, vt[v].xsop);
      run_stream(vt[v].inst, vt[v].rmode, 0, st);
      check_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d total", v), got_q.size(), vt[v].exp_total);
      if (got_q.size() > 0) chk($sformatf("vec%0d err", v), got_q[got_q.size() - 1].err, vt[v].exp_err);
      if (!vt[v].exp_err) chk($sformatf("vec%0d residue", v), got_residue(0), 32'hDEBB20E3);
    end

    // Single-beat frame followed immediately by another frame.
    new_stream();
    pay.delete();
    pay.push_back(8'hAA);
    add_frame(1'b1, -1, -1);
    fill_pay(3, 7);
    add_frame(1'b1, -1, -1);
    run_stream(1, 0, 0, st);
    chk("b2b stalls", st, 63);
    chk("b2b total", got_q.size(), 128);
    check_stream("b2b");

    // Reset pulse while the FCS is going out, then a fresh frame.
    fill_pay(14, 3);
    new_stream();
    add_frame(1'b1, -1, -1);
    run_stream(1, 0, 61, st);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_vld[1]) seen++;
    end
    chk("rst stale", seen, 0);
    fill_pay(10, 9);
    new_stream();
    add_frame(1'b1, -1, -1);
    run_stream(1, 1, 0, st);
    check_stream("post-rst");
    chk("post-rst residue", got_residue(0), 32'hDEBB20E3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
